div_controller: RTL
===================

// Module: div_controller
// PURPOSE
//   FSM that drives the divider datapath control inputs (load/add/shift/inbit/sel) to run an
//   8-bit / 7-bit unsigned restoring division. Datapath results: quotient = R[7:0], remainder = R[15:9].
//   Sits between the system start/done handshake and the datapath.
//   Reads datapath sign (R[15]) to decide whether to restore or to shift in a 1.
// PARAMETERS
//   N_BITS   8   quotient width = number of iterations
//   CNT_W    4   iteration counter width (>= clog2(N_BITS)+1)
// PORTS
//   clk      in   1  single clock, rising edge
//   reset    in   1  asynchronous, active-low; 0 forces IDLE immediately
//   start    in   1  request division; sampled only in IDLE
//   sign     in   1  datapath remainder-register MSB R[15] (registered value)
//   load     out  1  load divisor register
//   add      out  1  1 = datapath adds divisor, 0 = subtracts
//   shift    out  1  shift datapath register left 1, inbit into R[0]
//   inbit    out  1  quotient bit shifted in
//   sel      out  2  01 adder/R[7:0], 10 {0,dividendin}, 11 hold R; 00 never driven
//   busy     out  1  1 whenever state != IDLE
//   done     out  1  one-cycle pulse: results valid in datapath
// BEHAVIOUR
//   - Moore outputs decoded from registered state. Reset/IDLE: load=0 add=0 shift=0 inbit=0
//     sel=11 busy=0 done=0; counter=0.
//   - IDLE: sel=11, shift=0 (datapath holds). start=1 -> LOAD, counter<=0.
//   - LOAD (1 cyc): load=1, sel=10, shift=1, inbit=0 -> R={8'h00,dividend}<<1. -> SUB.
//   - SUB  (1 cyc): add=0, sel=01, shift=0 -> R[15:8]-=divisor. -> TEST.
//   - TEST (1 cyc): sign=1: add=1, sel=01, shift=1, inbit=0 (restore and shift in 0).
//                   sign=0: sel=11, shift=1, inbit=1 (shift in 1).
//     counter==N_BITS-1 -> DONE; else counter+1 -> SUB.
//   - DONE (1 cyc): done=1, sel=11, shift=0. -> IDLE unconditionally.
//   - add is don't-care when sel!=01; drive 0.
//   - Latency: start-sampling edge enters LOAD; DONE entered 1+2*N_BITS = 17 edges later.
//     R holds results in DONE and afterwards while IDLE.
//   - start while busy (LOAD/SUB/TEST/DONE): ignored, no queuing.
//   - start held high: DONE -> IDLE -> LOAD back-to-back. One idle cycle between operations.
//   - sign is sampled only in TEST and ignored in all other states.
//   - Divisor 0: no special case; quotient=8'hFF, remainder=dividend[6:0].
//   - Reset asserted mid-operation: FSM -> IDLE and counter -> 0 asynchronously.
//     Datapath contents undefined until next LOAD; done never pulses for the aborted operation.
//   - Illegal state encoding: recover to IDLE on next edge.
//   - Counter wraps never: cleared in LOAD, compared at N_BITS-1.
// STRUCTURE
//   - Shared include div_defs.vh:
//       state codes IDLE/LOAD/SUB/TEST/DONE (3-bit);
//       SEL_ADDER=2'b01, SEL_DIVIDEND=2'b10, SEL_HOLD=2'b11;
//       DIV_N_BITS=8.
//   - One sub-module div_iter_counter:
//       clear, enable, last flag (count==N_BITS-1);
//       async active-low reset.
//   - FSM next-state and output decode stay in div_controller. Top-level bench instantiates with datapath.
// TESTING
//   - 0x64 / 0x07: start pulse -> done exactly 17 edges after start sample; quotient 0x0E, remainder 0x02.
//   - 0xFF / 0x7F -> quotient 0x02, remainder 0x01.
//   - 0x05 / 0x07 -> quotient 0x00, remainder 0x05.
//   - 0x2A / 0x00 -> quotient 0xFF, remainder 0x2A.
//   - Reset pulse low in the 3rd TEST cycle:
//       outputs return to reset values same cycle;
//       no done pulse;
//       next start gives 0x64/0x07 -> 0x0E r 0x02.
//   - start held high for 3 operations:
//       done pulses 1 cycle each, spaced 19 edges;
//       start pulses during busy do not shorten or restart the operation;
//       sel never 00.

Source files
------------

// File: rtl/div_controller_pkg.sv
//==============================================================================
// Module : div_controller_pkg
// Brief  : State codes, datapath select codes and output decode shared by the
//          restoring-divider controller and its iteration counter.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package div_controller_pkg;

    localparam int DIV_N_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SUB  = 3'd2,
        ST_TEST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] SEL_ADDER    = 2'b01;
    localparam logic [1:0] SEL_DIVIDEND = 2'b10;
    localparam logic [1:0] SEL_HOLD     = 2'b11;

    // test marks the one state whose add/sel/inbit follow the live sign input
    typedef struct packed {
        logic       load;
        logic       shift;
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic       test;
    } ctrl_out_t;

    function automatic ctrl_out_t decode_outputs(input state_t s);
        ctrl_out_t o;
        o = '{load: 1'b0, shift: 1'b0, sel: SEL_HOLD, busy: 1'b1, done: 1'b0, test: 1'b0};
        case (s)
            ST_LOAD: begin
                o.load  = 1'b1;
                o.shift = 1'b1;
                o.sel   = SEL_DIVIDEND;
            end
            ST_SUB:  o.sel   = SEL_ADDER;
            ST_TEST: begin
                o.shift = 1'b1;
                o.test  = 1'b1;
            end
            ST_DONE: o.done  = 1'b1;
            default: o.busy  = 1'b0;
        endcase
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_controller_if.sv
//==============================================================================
// Module : div_controller_if
// Brief  : Handshake and datapath-control bundle between controller and datapath.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface div_controller_if;
    logic       start;
    logic       sign;
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
    logic       busy;
    logic       done;

    modport master (
        input  start, sign,
        output load, add, shift, inbit, sel, busy, done
    );

    modport slave (
        output start, sign,
        input  load, add, shift, inbit, sel, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/div_iter_counter.sv
//==============================================================================
// Module : div_iter_counter
// Brief  : Iteration counter for the divider; flags the final iteration.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module div_iter_counter #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign last = (r_count == CNT_W'(N_BITS - 1));

endmodule

`default_nettype wire

// File: rtl/div_controller.sv
//==============================================================================
// Module : div_controller
// Brief  : Control FSM for an 8-bit / 7-bit unsigned restoring divider datapath.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module div_controller
    import div_controller_pkg::*;
#(
    parameter int N_BITS = DIV_N_BITS,
    parameter int CNT_W  = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    div_controller_if.master ctl
);

    state_t    r_state;
    ctrl_out_t r_out;
    logic      w_last;
    logic      w_cnt_clear;
    logic      w_cnt_enable;

    assign w_cnt_clear  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_cnt_enable = (r_state == ST_TEST);

    div_iter_counter #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_cnt_clear),
        .enable (w_cnt_enable),
        .last   (w_last)
    );

    // Outputs are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_out   <= decode_outputs(ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        r_state <= ST_LOAD;
                        r_out   <= decode_outputs(ST_LOAD);
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_SUB;
                    r_out   <= decode_outputs(ST_SUB);
                end
                ST_SUB: begin
                    r_state <= ST_TEST;
                    r_out   <= decode_outputs(ST_TEST);
                end
                ST_TEST: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_out   <= decode_outputs(ST_DONE);
                    end else begin
                        r_state <= ST_SUB;
                        r_out   <= decode_outputs(ST_SUB);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= decode_outputs(ST_IDLE);
                end
            endcase
        end
    end

    // In TEST a negative trial difference is restored (add, shift 0); otherwise hold and shift 1
    assign ctl.sel   = r_out.test ? (ctl.sign ? SEL_ADDER : SEL_HOLD) : r_out.sel;
    assign ctl.add   = r_out.test & ctl.sign;
    assign ctl.inbit = r_out.test & ~ctl.sign;
    assign ctl.load  = r_out.load;
    assign ctl.shift = r_out.shift;
    assign ctl.busy  = r_out.busy;
    assign ctl.done  = r_out.done;

endmodule

`default_nettype wire
